aes_shiftrows_stream: RTL and testbench



---
 rtl/aes_shiftrows_stream.sv | 138 +++++++++++++
 tb/tb_aes_shiftrows_stream.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shiftrows_stream.sv
// aes_shiftrows_stream: byte-serial AES ShiftRows permutation unit.
// Buffers one 16-element state, then replays it in ShiftRows order.
// Ports: clk, rst_n (async, active-low), flush (sync abort);
//   in_valid/in_ready/in_data  : element stream in, state byte 0 first;
//   out_valid/out_ready/out_data/out_last : permuted stream out.
// Option: define AES_SHIFTROWS_INV_EN to add input inv, which selects
//   the inverse map for a block (sampled on entry to DRAIN).
module aes_shiftrows_stream #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
`ifdef AES_SHIFTROWS_INV_EN
  input  logic          inv,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    wr_cnt;
  logic [3:0]    rd_cnt;
  logic [BW-1:0] mem [16];
  logic          acc;
  logic          hs;
  logic          fill_done;
  logic          inv_q;
  logic [1:0]    row;
  logic [1:0]    col;
  logic [1:0]    src_col;
  logic [3:0]    src;

  // Moore handshakes: acceptance depends only on state,
  // never on the ready/valid being driven back at us.
  assign acc       = in_valid & (state == FILL);
  assign hs        = out_ready & (state == DRAIN);
  assign fill_done = acc & (wr_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (fill_done) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_cnt == 4'd15);
        if (hs && rd_cnt == 4'd15) begin
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
    if (flush) begin
      state_nx = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= 4'd0;
      rd_cnt <= 4'd0;
    end else if (flush) begin
      wr_cnt <= 4'd0;
      rd_cnt <= 4'd0;
    end else begin
      if (acc) begin
        wr_cnt <= wr_cnt + 4'd1;
      end
      if (hs) begin
        rd_cnt <= rd_cnt + 4'd1;
      end
    end
  end

  // Storage only; never read outside DRAIN, so no reset.
  always_ff @(posedge clk) begin
    if (acc && !flush) begin
      mem[wr_cnt] <= in_data;
    end
  end

`ifdef AES_SHIFTROWS_INV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (fill_done && !flush) begin
      inv_q <= inv;
    end
  end
`else
  assign inv_q = 1'b0;
`endif

  // k = 4*c + r; source column wraps mod 4 in 2 bits.
  assign row = rd_cnt[1:0];
  assign col = rd_cnt[3:2];

  always_comb begin
    src_col = col + row;
    unique case (1'b1)
      inv_q:   src_col = col - row;
      default: src_col = col + row;
    endcase
  end

  assign src = {src_col, row};

  // Gated so the port never shows X from the unreset buffer.
  assign out_data = (state == DRAIN) ? mem[src] : '0;

endmodule

// File: tb/tb_aes_shiftrows_stream.sv
// tb_aes_shiftrows_stream: randomized self-checking bench.
// Reference: ShiftRows computed from (row, column) arithmetic.
module tb_aes_shiftrows_stream;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
`ifdef AES_SHIFTROWS_INV_EN
  logic       inv;
`endif

  int checks;
  int failures;

  logic [7:0] blk [16];
  logic [7:0] got_data [$];
  logic       got_last [$];
  int         accept_cyc;
  int         first_out_cyc;
  int         total_cyc;
  int         stall_bad;
  int         stall_seen;
  int         ready_bad;
  bit         exp_inv;
  bit         inv_scramble;

  aes_shiftrows_stream #(
    .BW(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
`ifdef AES_SHIFTROWS_INV_EN
    .inv      (inv),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output k sits at row k%4, column k/4 and takes the input
  // element from the same row, column shifted by +row (or -row).
  function automatic logic [7:0] model(input int k, input bit iv);
    int r;
    int c;
    int sc;
    r  = k % 4;
    c  = k / 4;
    sc = iv ? (c - r + 4) % 4 : (c + r) % 4;
    return blk[4 * sc + r];
  endfunction

  // rdy_mode: 0 always, 1 toggle, 2 random
  // vld_mode: 0 always, 1 random gaps
  task automatic run_block(input int rdy_mode, input int vld_mode,
                           input int stop_in, input int stop_out);
    int  ni;
    int  no;
    int  cyc;
    bit  prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    got_data.delete();
    got_last.delete();
    accept_cyc    = -1;
    first_out_cyc = -1;
    stall_bad     = 0;
    stall_seen    = 0;
    ready_bad     = 0;
    prev_stall    = 0;
    prev_data     = '0;
    prev_last     = 0;
    ni  = 0;
    no  = 0;
    cyc = 0;
`ifdef AES_SHIFTROWS_INV_EN
    inv = exp_inv;
`endif
    while (cyc < 400 && !(ni >= stop_in && no >= stop_out)) begin
      @(negedge clk);
      in_valid = (ni < 16) && (vld_mode == 0 || $urandom_range(0, 1) == 1);
      in_data  = in_valid ? blk[ni] : 8'($urandom);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 2) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
`ifdef AES_SHIFTROWS_INV_EN
      if (inv_scramble && out_valid) inv = 1'($urandom);
`endif
      if (prev_stall) begin
        stall_seen++;
        if (!out_valid || out_data !== prev_data || out_last !== prev_last)
          stall_bad++;
      end
      if (in_ready !== !out_valid) ready_bad++;
      if (in_valid && in_ready) begin
        ni++;
        if (ni == 16) accept_cyc = cyc;
      end
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        no++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      cyc++;
    end
    total_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef AES_SHIFTROWS_INV_EN
    inv = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_last got=%b want=0", out_last);
    end
    checks++;
    if ($isunknown(out_data)) begin
      failures++;
      $display("FAIL reset_out_data got=%h want=known", out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] golden [16];
    golden = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
               8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    exp_inv = 0;
    run_block(0, 0, 16, 16);
    checks++;
    if (got_data.size() != 16) begin
      failures++;
      $display("FAIL basic_count got=%0d want=16", got_data.size());
    end
    for (int k = 0; k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== golden[k]) begin
        failures++;
        $display("FAIL basic_data k=%0d got=%h want=%h",
                 k, got_data[k], golden[k]);
      end
      checks++;
      if (got_last[k] !== (k == 15)) begin
        failures++;
        $display("FAIL basic_last k=%0d got=%b want=%b",
                 k, got_last[k], (k == 15));
      end
    end
    checks++;
    if (first_out_cyc != accept_cyc + 1) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=%0d",
               first_out_cyc, accept_cyc + 1);
    end
    checks++;
    if (total_cyc != 32) begin
      failures++;
      $display("FAIL basic_cycles got=%0d want=32", total_cyc);
    end
    checks++;
    if (ready_bad != 0) begin
      failures++;
      $display("FAIL basic_ready_excl got=%0d want=0", ready_bad);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    exp_inv = 0;
    run_block(1, 0, 16, 16);
    checks++;
    if (got_data.size() != 16) begin
      failures++;
      $display("FAIL bp_count got=%0d want=16", got_data.size());
    end
    for (int k = 0; k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== model(k, 0) || got_last[k] !== (k == 15)) begin
        failures++;
        $display("FAIL bp_data k=%0d got=%h/%b want=%h/%b",
                 k, got_data[k], got_last[k], model(k, 0), (k == 15));
      end
    end
    checks++;
    if (stall_seen != 15 || stall_bad != 0) begin
      failures++;
      $display("FAIL bp_stable stalls=%0d unstable=%0d want=15/0",
               stall_seen, stall_bad);
    end
    checks++;
    if (ready_bad != 0) begin
      failures++;
      $display("FAIL bp_in_ready got=%0d want=0", ready_bad);
    end
    checks++;
    if (total_cyc != 47) begin
      failures++;
      $display("FAIL bp_cycles got=%0d want=47", total_cyc);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = 8'(b * 240 + i);
      exp_inv = 0;
      run_block(0, 0, 16, 16);
      checks++;
      if (got_data.size() != 16 || total_cyc != 32) begin
        failures++;
        $display("FAIL b2b_shape blk=%0d got=%0d/%0d want=16/32",
                 b, got_data.size(), total_cyc);
      end
      for (int k = 0; k < got_data.size(); k++) begin
        checks++;
        if (got_data[k] !== model(k, 0)) begin
          failures++;
          $display("FAIL b2b_data blk=%0d k=%0d got=%h want=%h",
                   b, k, got_data[k], model(k, 0));
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    exp_inv = 0;
    // abort after 9 accepts; the flush cycle's element is dropped
    run_block(0, 0, 9, 0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_fill got=%b/%b want=1/0", in_ready, out_valid);
    end
    // flush coinciding with the 16th accept must not enter DRAIN
    run_block(0, 0, 15, 0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_last_acc got=%b/%b want=1/0", in_ready, out_valid);
    end
    // flush coinciding with an output handshake mid-drain
    run_block(0, 0, 16, 3);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drain got=%b/%b want=1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    run_block(0, 0, 16, 16);
    checks++;
    if (got_data.size() != 16 || total_cyc != 32) begin
      failures++;
      $display("FAIL flush_after got=%0d/%0d want=16/32",
               got_data.size(), total_cyc);
    end
    for (int k = 0; k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== model(k, 0) || got_last[k] !== (k == 15)) begin
        failures++;
        $display("FAIL flush_data k=%0d got=%h/%b want=%h/%b",
                 k, got_data[k], got_last[k], model(k, 0), (k == 15));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
    exp_inv = 0;
    run_block(0, 0, 16, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL arst_outputs got=%b/%b/%b want=0/1/0",
               out_valid, in_ready, out_last);
    end
    checks++;
    if ($isunknown(out_data)) begin
      failures++;
      $display("FAIL arst_out_data got=%h want=known", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    run_block(0, 0, 16, 16);
    checks++;
    if (got_data.size() != 16 || total_cyc != 32) begin
      failures++;
      $display("FAIL arst_after got=%0d/%0d want=16/32",
               got_data.size(), total_cyc);
    end
    for (int k = 0; k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== model(k, 0) || got_last[k] !== (k == 15)) begin
        failures++;
        $display("FAIL arst_data k=%0d got=%h/%b want=%h/%b",
                 k, got_data[k], got_last[k], model(k, 0), (k == 15));
      end
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
`ifdef AES_SHIFTROWS_INV_EN
      exp_inv      = 1'($urandom);
      inv_scramble = 1;
`else
      exp_inv = 0;
`endif
      run_block(2, 1, 16, 16);
      checks++;
      if (got_data.size() != 16) begin
        failures++;
        $display("FAIL rand_count blk=%0d got=%0d want=16",
                 b, got_data.size());
      end
      for (int k = 0; k < got_data.size(); k++) begin
        checks++;
        if (got_data[k] !== model(k, exp_inv) ||
            got_last[k] !== (k == 15)) begin
          failures++;
          $display("FAIL rand_data blk=%0d k=%0d got=%h/%b want=%h/%b",
                   b, k, got_data[k], got_last[k],
                   model(k, exp_inv), (k == 15));
        end
      end
      checks++;
      if (stall_bad != 0 || ready_bad != 0) begin
        failures++;
        $display("FAIL rand_hs blk=%0d unstable=%0d ready=%0d want=0/0",
                 b, stall_bad, ready_bad);
      end
    end
    inv_scramble = 0;
  endtask

`ifdef AES_SHIFTROWS_INV_EN
  task automatic test_inverse();
    logic [7:0] golden [16];
    golden = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
               8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    exp_inv      = 1;
    inv_scramble = 1;
    run_block(0, 0, 16, 16);
    inv_scramble = 0;
    checks++;
    if (got_data.size() != 16) begin
      failures++;
      $display("FAIL inv_count got=%0d want=16", got_data.size());
    end
    for (int k = 0; k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== golden[k]) begin
        failures++;
        $display("FAIL inv_data k=%0d got=%h want=%h",
                 k, got_data[k], golden[k]);
      end
    end
  endtask
`endif

  initial begin
    checks       = 0;
    failures     = 0;
    exp_inv      = 0;
    inv_scramble = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef AES_SHIFTROWS_INV_EN
    test_inverse();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
